// File: rtl/logic32_serial_unit.sv
// Serial 32-bit bitwise logic unit: AND/OR/NOR/INV computed SLICE_W bits
// per cycle, LSB slice first, with a one-cycle DONE pulse.
module logic32_serial_unit #(
  parameter int SLICE_W = 4,
  parameter int NSLICE  = 32 / SLICE_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  OPRN,
  input  logic [31:0] OP1,
  input  logic [31:0] OP2,
  output logic [31:0] R,
  output logic        BUSY,
  output logic        DONE
);

  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [31:0] LOW_MASK =
    32'((64'd1 << SLICE_W) - 64'd1);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  generate
    if (SLICE_W != 1 && SLICE_W != 2 && SLICE_W != 4 &&
        SLICE_W != 8 && SLICE_W != 16 && SLICE_W != 32) begin : g_bad_w
      $error("SLICE_W must be 1, 2, 4, 8, 16 or 32");
    end
    if (NSLICE != 32 / SLICE_W) begin : g_bad_n
      $error("NSLICE is derived from SLICE_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [1:0]    opr_q, opr_d;
  logic [31:0]   r_q, r_d;

  logic [31:0]   full;
  logic [31:0]   mask;

  always_comb begin
    full = '0;
    unique case (opr_q)
      2'b00: full = a_q & b_q;
      2'b01: full = a_q | b_q;
      2'b10: full = ~(a_q | b_q);
      2'b11: full = ~a_q;
      default: full = '0;
    endcase
  end

  assign mask = LOW_MASK << (32'(cnt_q) * SLICE_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    opr_d   = opr_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE, FIN: begin
        if (START) begin
          a_d     = OP1;
          b_d     = OP2;
          opr_d   = OPRN;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Unwritten bits stay 0, so OR-ing in the masked slice suffices.
        r_d   = r_q | (full & mask);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opr_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opr_q   <= opr_d;
      r_q     <= r_d;
    end
  end

  assign R    = r_q;
  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_logic32_serial_unit.sv
// Randomized self-checking bench for logic32_serial_unit against a
// transaction-level model of the bitwise result and its slice timing.
module tb_logic32_serial_unit;

  localparam int W  = 4;
  localparam int NS = 32 / W;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [1:0]  OPRN;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [31:0] R;
  logic        BUSY;
  logic        DONE;

  int n_chk = 0;
  int n_err = 0;

  logic32_serial_unit #(.SLICE_W(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN),
    .OP1(OP1), .OP2(OP2), .R(R), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0]  op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a | b);
      default: return ~a;
    endcase
  endfunction

  // Bits of the result that exist after k slices have been written.
  function automatic logic [31:0] low_bits(input int k);
    logic [63:0] m;
    m = (64'd1 << (k * W)) - 64'd1;
    return m[31:0];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full operation; scramble perturbs inputs and START during RUN.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input bit scramble);
    logic [31:0] exp;
    exp   = model(a, b, op);
    OP1   = a;
    OP2   = b;
    OPRN  = op;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("run_busy0", {31'd0, BUSY}, 32'd1);
    chk("run_r0", R, 32'd0);
    for (int k = 1; k < NS; k++) begin
      if (scramble) begin
        OP1   = $urandom;
        OP2   = $urandom;
        OPRN  = 2'($urandom_range(0, 3));
        START = 1'($urandom_range(0, 1));
      end
      tick();
      chk("run_busy", {31'd0, BUSY}, 32'd1);
      chk("run_done", {31'd0, DONE}, 32'd0);
      chk("run_part", R, exp & low_bits(k));
    end
    tick();
    START = 1'b0;
    chk("fin_done", {31'd0, DONE}, 32'd1);
    chk("fin_busy", {31'd0, BUSY}, 32'd0);
    chk("fin_r", R, exp);
    tick();
    chk("idle_done", {31'd0, DONE}, 32'd0);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
    chk("idle_hold", R, exp);
  endtask

  initial begin
    logic [31:0] ta, tb;
    logic [1:0]  to;
    logic [31:0] texp;
    int ndone;

    RST = 1'b0; START = 1'b0; OPRN = 2'b00; OP1 = '0; OP2 = '0;
    tick();
    START = 1'b1;
    tick();
    chk("rst_r", R, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    START = 1'b0;
    RST   = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, BUSY}, 32'd0);

    do_op(32'hDA00006D, 32'hFFFFFFFF, 2'b00, 1'b0);
    do_op(32'hDA00006D, 32'h9A00004D, 2'b00, 1'b0);
    do_op(32'hDA00006D, 32'h9A00004D, 2'b01, 1'b0);
    do_op(32'hDA00006D, 32'hDA00006D, 2'b10, 1'b0);
    do_op(32'hDA00006D, 32'h12345678, 2'b11, 1'b0);
    do_op(32'hFFFFFFFF, 32'h00000000, 2'b01, 1'b1);

    OP1 = 32'hA5A5A5A5; OP2 = 32'h0F0F0F0F; OPRN = 2'b01;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("abort_r", R, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    ndone = 0;
    for (int k = 0; k < NS + 2; k++) begin
      tick();
      if (DONE) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);

    ta = $urandom; tb = $urandom; to = 2'($urandom_range(0, 3));
    texp = model(ta, tb, to);
    OP1 = ta; OP2 = tb; OPRN = to;
    START = 1'b1;
    tick();
    ndone = 0;
    for (int c = 1; c <= 3 * (NS + 1); c++) begin
      tick();
      chk("b2b_done", {31'd0, DONE}, {31'd0, (c % (NS + 1)) == NS});
      chk("b2b_busy", {31'd0, BUSY}, {31'd0, (c % (NS + 1)) != NS});
      if (DONE) begin
        ndone++;
        chk("b2b_r", R, texp);
        ta = $urandom; tb = $urandom; to = 2'($urandom_range(0, 3));
        texp = model(ta, tb, to);
        OP1 = ta; OP2 = tb; OPRN = to;
      end
    end
    START = 1'b0;
    chk("b2b_count", 32'(ndone), 32'd3);
    for (int k = 0; k < NS + 2; k++) tick();
    chk("b2b_idle", {31'd0, BUSY}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      do_op($urandom, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
